// File: rtl/cam_pkg.sv
// cam_pkg: capture FSM state encoding and default frame geometry
// for the OV7670 pixel path.
package cam_pkg;

  localparam int CAM_H_ACTIVE = 640;
  localparam int CAM_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_VS    = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_ACTIVE     = 2'd3
  } cam_state_e;

endpackage

// File: rtl/cam_edge_det.sv
// cam_edge_det: one-cycle delayed copy of a camera sync line
// with combinational rise/fall pulses.
module cam_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) d_q <= 1'b0;
    else         d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: OV7670 frame-capture sequencer on cam_pclk.
// Define CAM_LINE_CHECK_EN to build the sticky line-length checker.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = CAM_H_ACTIVE,
  parameter int V_ACTIVE = CAM_V_ACTIVE,
  parameter int XW       = 11,
  parameter int YW       = 11,
  parameter int BYTE_SEL = 1
) (
  input  logic          cam_pclk,
  input  logic          reset,
  input  logic          cam_vs,
  input  logic          cam_href,
  input  logic [7:0]    cam_byte,
  input  logic          mode_cont,
  input  logic          start,
  output logic          wr_en,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          err_line
);

  localparam logic          SEL  = 1'(BYTE_SEL);
  localparam logic [XW-1:0] XLIM = XW'(H_ACTIVE);
  localparam logic [YW-1:0] YLIM = YW'(V_ACTIVE);

  cam_state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d, wr_x_q, wr_x_d;
  logic [YW-1:0] y_q, y_d, wr_y_q, wr_y_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic phase_q, phase_d;
  logic wr_en_q, wr_en_d;
  logic fdone_q, fdone_d;

  logic href_rise, href_fall;
  logic vs_rise, vs_fall;
  logic unused_edges;

  cam_edge_det u_href (
    .clk_i  (cam_pclk),
    .rst_ni (reset),
    .d_i    (cam_href),
    .rise_o (href_rise),
    .fall_o (href_fall)
  );

  cam_edge_det u_vs (
    .clk_i  (cam_pclk),
    .rst_ni (reset),
    .d_i    (cam_vs),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  assign unused_edges = href_rise | vs_fall;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    phase_d   = phase_q;
    wr_en_d   = 1'b0;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    wr_data_d = wr_data_q;
    fdone_d   = 1'b0;
    fcnt_d    = fcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (cam_vs) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (!cam_vs) begin
          state_d = ST_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        // frame end wins over a coincident line end
        if (vs_rise) begin
          fdone_d = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
          state_d = mode_cont ? ST_WAIT_FRAME : ST_IDLE;
        end else if (href_fall) begin
          if (x_q != '0) begin
            x_d = '0;
            if (y_q != '1) y_d = y_q + 1'b1;
          end
          phase_d = 1'b0;
        end else if (cam_href && !cam_vs) begin
          phase_d = ~phase_q;
          if (phase_q == SEL) begin
            if (x_q < XLIM && y_q < YLIM) begin
              wr_en_d   = 1'b1;
              wr_x_d    = x_q;
              wr_y_d    = y_q;
              wr_data_d = cam_byte;
            end
            if (x_q != '1) x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cam_pclk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      phase_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_data_q <= '0;
      fdone_q   <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      phase_q   <= phase_d;
      wr_en_q   <= wr_en_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_data_q <= wr_data_d;
      fdone_q   <= fdone_d;
      fcnt_q    <= fcnt_d;
    end
  end

`ifdef CAM_LINE_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && start)
      err_d = 1'b0;
    else if (state_q == ST_ACTIVE && href_fall && x_q != XLIM)
      err_d = 1'b1;
  end

  always_ff @(posedge cam_pclk) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_line = err_q;
`else
  assign err_line = 1'b0;
`endif

  assign wr_en      = wr_en_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = fdone_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: random camera framing against a
// frame/line-level write model, reduced 16x6 geometry.
module tb_cam_capture_ctrl;

  localparam int H = 16;
  localparam int V = 6;

`ifdef CAM_LINE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0;
  logic href = 1'b0;
  logic [7:0] byt = 8'h00;
  logic mode = 1'b0;
  logic start = 1'b0;

  logic wr_en;
  logic [10:0] wr_x;
  logic [10:0] wr_y;
  logic [7:0] wr_data;
  logic busy;
  logic frame_done;
  logic [7:0] frame_cnt;
  logic err_line;

  wr_t expq[$];
  int n_vec = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_fd = 0;
  int fcnt = 0;
  bit cap = 1'b0;
  bit exp_err = 1'b0;
  bit st_req = 1'b0;

  always #5 clk = ~clk;

  cam_capture_ctrl #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .XW       (11),
    .YW       (11),
    .BYTE_SEL (1)
  ) dut (
    .cam_pclk   (clk),
    .reset      (rst_n),
    .cam_vs     (vs),
    .cam_href   (href),
    .cam_byte   (byt),
    .mode_cont  (mode),
    .start      (start),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_line   (err_line)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (wr_en) begin
      n_wr++;
      if (expq.size() > 0) e = expq.pop_front();
      else e = '1;
      chk("wr_x", 32'(wr_x), 32'(e.x));
      chk("wr_y", 32'(wr_y), 32'(e.y));
      chk("wr_data", 32'(wr_data), 32'(e.d));
    end
    if (frame_done) n_fd++;
  end

  task automatic cyc(input logic v, input logic h,
                     input logic [7:0] b);
    @(negedge clk);
    vs = v;
    href = h;
    byt = b;
    start = st_req;
    st_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    st_req = 1'b0;
    idle(2);
    rst_n = 1'b1;
    expq.delete();
    cap = 1'b0;
    fcnt = 0;
    exp_err = 1'b0;
    n_fd = 0;
    n_wr = 0;
  endtask

  task automatic arm();
    st_req = 1'b1;
    exp_err = 1'b0;
    idle(3);
  endtask

  task automatic line(input int n, input int y,
                      input bit fix);
    logic [7:0] b;
    int g;
    for (int j = 0; j < n; j++) begin
      b = 8'($urandom);
      if (fix && j < 4) b = 8'(16 * (j + 1));
      if (cap && j % 2 == 1 && j / 2 < H && y < V)
        expq.push_back('{x: 11'(j / 2), y: 11'(y), d: b});
      cyc(1'b0, 1'b1, b);
    end
    if (cap && n / 2 != H) exp_err = 1'b1;
    g = $urandom_range(2, 5);
    idle(g);
  endtask

  task automatic frame(input bit c, input int nl,
                       input int lng_l, input int lng_n,
                       input int st_l, input bit rnd,
                       input bit fix);
    int y;
    int n;
    y = 0;
    if (cap) fcnt++;
    cap = c;
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    idle(3);
    for (int l = 0; l < nl; l++) begin
      if (l == st_l) st_req = 1'b1;
      n = (l == lng_l) ? lng_n : 2 * H;
      if (rnd) n = $urandom_range(1, 2 * H + 6);
      line(n, y, fix && l == 0);
      if (n >= 2) y++;
    end
  endtask

  task automatic end_vs();
    if (cap) fcnt++;
    cap = 1'b0;
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    idle(6);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_xy"}, {10'd0, wr_y, wr_x}, 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fdone"}, 32'(frame_done), 0);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 0);
    chk({tag, "_err"}, 32'(err_line), 0);
  endtask

  task automatic chk_end(input string tag, input int nwr);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 32'(fcnt));
    chk({tag, "_fdone_n"}, 32'(n_fd), 32'(fcnt));
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_q_left"}, 32'(expq.size()), 0);
    chk({tag, "_err"}, 32'(err_line), 32'(CHK & exp_err));
    if (nwr >= 0) chk({tag, "_nwr"}, 32'(n_wr), 32'(nwr));
  endtask

  initial begin
    logic [7:0] b;
    do_reset();
    idle(1);
    chk_rst("por");

    // single-shot: only the first frame after start is written
    mode = 1'b0;
    arm();
    chk("ss_busy", 32'(busy), 1);
    frame(1'b1, V, -1, 0, -1, 1'b0, 1'b1);
    frame(1'b0, V, -1, 0, -1, 1'b0, 1'b0);
    end_vs();
    chk_end("ss", H * V);

    // start mid-frame waits for the next frame boundary
    do_reset();
    mode = 1'b0;
    frame(1'b0, V, -1, 0, 3, 1'b0, 1'b0);
    frame(1'b1, V, -1, 0, -1, 1'b0, 1'b0);
    end_vs();
    chk_end("mid", H * V);

    // continuous with an overlong line; late start is ignored
    do_reset();
    mode = 1'b1;
    arm();
    frame(1'b1, V, -1, 0, -1, 1'b0, 1'b0);
    frame(1'b1, V, 5, 2 * H + 20, -1, 1'b0, 1'b0);
    frame(1'b1, V, -1, 0, 2, 1'b0, 1'b0);
    mode = 1'b0;
    end_vs();
    chk_end("cont", 3 * H * V);

    // random line counts and lengths, continuous
    do_reset();
    mode = 1'b1;
    arm();
    for (int f = 0; f < 4; f++)
      frame(1'b1, $urandom_range(V - 2, V + 2),
            -1, 0, -1, 1'b1, 1'b0);
    mode = 1'b0;
    end_vs();
    chk_end("rnd", -1);

    // reset in the middle of line 3
    do_reset();
    mode = 1'b1;
    arm();
    frame(1'b1, 3, -1, 0, -1, 1'b0, 1'b0);
    for (int j = 0; j < 11; j++) begin
      b = 8'($urandom);
      if (j % 2 == 1)
        expq.push_back('{x: 11'(j / 2), y: 11'd3, d: b});
      cyc(1'b0, 1'b1, b);
    end
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 8'h00);
    chk_rst("mrst");
    chk("mrst_q_left", 32'(expq.size()), 0);
    rst_n = 1'b1;
    cap = 1'b0;
    fcnt = 0;
    exp_err = 1'b0;
    n_fd = 0;
    n_wr = 0;
    repeat (9) cyc(1'b0, 1'b1, 8'($urandom));
    idle(3);
    line(2 * H, 4, 1'b0);
    arm();
    frame(1'b1, V, -1, 0, -1, 1'b0, 1'b0);
    mode = 1'b0;
    end_vs();
    chk_end("mrst", H * V);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
